// File: rtl/pwm_seq_ctrl_pkg.sv
// Shared types for the PWM sequencer: command opcodes, sequencer states and
// the on/off encoding driven to each pwm_16bits channel.
package pwm_seq_ctrl_pkg;

    localparam int PWMCOUNT_WIDTH = 16;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } pwm_onoff_e;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_START = 2'd2,
        OP_STOP  = 2'd3
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwm_seq_ctrl_chan_cfg.sv
// One channel's period / compare / initial-carrier register set. A compare
// larger than the period is stored as the period so the channel never sticks.
module pwm_chan_cfg
    import pwm_seq_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [PWMCOUNT_WIDTH-1:0] wr_period,
    input  logic [PWMCOUNT_WIDTH-1:0] wr_compare,
    input  logic [PWMCOUNT_WIDTH-1:0] wr_init,
    output logic [PWMCOUNT_WIDTH-1:0] period,
    output logic [PWMCOUNT_WIDTH-1:0] compare,
    output logic [PWMCOUNT_WIDTH-1:0] init_carr,
    output logic                      clamp
);

    assign clamp = (wr_compare > wr_period);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs as they were just before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period    <= '0;
            compare   <= '0;
            init_carr <= '0;
        end else if (we) begin
            period    <= wr_period;
            compare   <= clamp ? wr_period : wr_compare;
            init_carr <= wr_init;
        end
    end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Command-driven sequencer: holds per-channel PWM configuration and enables or
// disables all channels together, with a settle window before enable and a
// drain window after disable.
module pwm_seq_ctrl
    import pwm_seq_ctrl_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int SETTLE = 4,
    parameter int DRAIN  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [2:0]                    cmd_chan,
    input  logic [PWMCOUNT_WIDTH-1:0]     cmd_period,
    input  logic [PWMCOUNT_WIDTH-1:0]     cmd_compare,
    input  logic [PWMCOUNT_WIDTH-1:0]     cmd_init,
    output logic [NCH*PWMCOUNT_WIDTH-1:0] period_o,
    output logic [NCH*PWMCOUNT_WIDTH-1:0] compare_o,
    output logic [NCH*PWMCOUNT_WIDTH-1:0] init_carr_o,
    output logic [NCH-1:0]                pwm_onoff_o,
    output logic                          busy,
    output logic                          err,
    output logic                          clamped
);

    localparam int CNT_W = $clog2(max_int(SETTLE, DRAIN) + 1);

    seq_state_e       state;
    logic [CNT_W-1:0] cnt;
    seq_op_e          op;
    logic             accept;
    logic             chan_ok;
    logic             wr_ok;
    logic             clamp_hit;
    logic [NCH-1:0]   chan_we;
    logic [NCH-1:0]   clamp_vec;

    assign op        = seq_op_e'(cmd_op);
    assign accept    = cmd_valid && cmd_ready;
    assign chan_ok   = (int'(cmd_chan) < NCH);
    assign wr_ok     = accept && (op == OP_WRITE) && chan_ok;
    assign clamp_hit = |(clamp_vec & chan_we);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign chan_we[i] = wr_ok && (int'(cmd_chan) == i);

        pwm_chan_cfg u_cfg (
            .clk        (clk),
            .reset      (reset),
            .we         (chan_we[i]),
            .wr_period  (cmd_period),
            .wr_compare (cmd_compare),
            .wr_init    (cmd_init),
            .period     (period_o[i*PWMCOUNT_WIDTH +: PWMCOUNT_WIDTH]),
            .compare    (compare_o[i*PWMCOUNT_WIDTH +: PWMCOUNT_WIDTH]),
            .init_carr  (init_carr_o[i*PWMCOUNT_WIDTH +: PWMCOUNT_WIDTH]),
            .clamp      (clamp_vec[i])
        );
    end

    // All outputs are registered; the async reset drops pwm_onoff_o at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_OFF;
            cnt         <= '0;
            pwm_onoff_o <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            err         <= 1'b0;
            clamped     <= 1'b0;
        end else begin
            if (clamp_hit) clamped <= 1'b1;
            if (accept && (op == OP_WRITE) && !chan_ok) err <= 1'b1;

            case (state)
                ST_OFF: begin
                    if (accept && (op == OP_START)) begin
                        state     <= ST_SETTLE;
                        cnt       <= CNT_W'(SETTLE);
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= ST_RUN;
                        pwm_onoff_o <= {NCH{PWM_ON}};
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept && (op == OP_START)) begin
                        err <= 1'b1;
                    end else if (accept && (op == OP_STOP)) begin
                        state       <= ST_STOPPING;
                        cnt         <= CNT_W'(DRAIN);
                        pwm_onoff_o <= '0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_STOPPING: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_OFF;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scoreboard bench for pwm_seq_ctrl: a time-based reference model predicts
// every cycle's outputs into a queue, and a negedge monitor compares them.
module tb_pwm_seq_ctrl;
    import pwm_seq_ctrl_pkg::*;

    localparam int NCH    = 3;
    localparam int SETTLE = 4;
    localparam int DRAIN  = 8;
    localparam int W      = NCH * 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'd0;
    logic [2:0]     cmd_chan = 3'd0;
    logic [15:0]    cmd_period = '0;
    logic [15:0]    cmd_compare = '0;
    logic [15:0]    cmd_init = '0;
    logic [W-1:0]   period_o, compare_o, init_carr_o;
    logic [NCH-1:0] pwm_onoff_o;
    logic           busy, err, clamped;

    pwm_seq_ctrl #(.NCH(NCH), .SETTLE(SETTLE), .DRAIN(DRAIN)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_chan    (cmd_chan),
        .cmd_period  (cmd_period),
        .cmd_compare (cmd_compare),
        .cmd_init    (cmd_init),
        .period_o    (period_o),
        .compare_o   (compare_o),
        .init_carr_o (init_carr_o),
        .pwm_onoff_o (pwm_onoff_o),
        .busy        (busy),
        .err         (err),
        .clamped     (clamped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   per;
        logic [W-1:0]   cmp;
        logic [W-1:0]   ini;
        logic [NCH-1:0] on;
        logic           busy;
        logic           ready;
        logic           err;
        logic           clamped;
    } snap_t;

    snap_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_acc = -1;

    // Reference model: configuration arrays plus the edge numbers at which
    // START / STOP were accepted; phases follow from plain arithmetic.
    int m_per[NCH];
    int m_cmp[NCH];
    int m_ini[NCH];
    bit m_err, m_clamped, m_running, m_stopped;
    int t_start, t_stop;

    function automatic bit m_settling(input int c);
        return m_running && (c < t_start + SETTLE);
    endfunction

    function automatic bit m_draining(input int c);
        return !m_running && m_stopped && (c < t_stop + DRAIN);
    endfunction

    function automatic bit m_ready(input int c);
        return !m_settling(c) && !m_draining(c);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_per[i] = 0;
            m_cmp[i] = 0;
            m_ini[i] = 0;
        end
        m_err = 0; m_clamped = 0; m_running = 0; m_stopped = 0;
        t_start = 0; t_stop = 0;
    endtask

    task automatic model_apply(input int c);
        case (cmd_op)
            OP_WRITE: begin
                if (int'(cmd_chan) < NCH) begin
                    m_per[cmd_chan] = int'(cmd_period);
                    m_ini[cmd_chan] = int'(cmd_init);
                    if (cmd_compare > cmd_period) begin
                        m_cmp[cmd_chan] = int'(cmd_period);
                        m_clamped = 1;
                    end else begin
                        m_cmp[cmd_chan] = int'(cmd_compare);
                    end
                end else begin
                    m_err = 1;
                end
            end
            OP_START: begin
                if (m_running) m_err = 1;
                else begin
                    m_running = 1; m_stopped = 0; t_start = c;
                end
            end
            OP_STOP: begin
                if (m_running) begin
                    m_running = 0; m_stopped = 1; t_stop = c;
                end
            end
            default: ;
        endcase
    endtask

    initial begin : model
        snap_t s;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (reset) begin
                model_reset();
            end else begin
                if (cmd_valid && m_ready(cyc - 1)) begin
                    model_apply(cyc);
                    last_acc = cyc;
                end
                for (int i = 0; i < NCH; i++) begin
                    s.per[i*16 +: 16] = 16'(m_per[i]);
                    s.cmp[i*16 +: 16] = 16'(m_cmp[i]);
                    s.ini[i*16 +: 16] = 16'(m_ini[i]);
                end
                s.on      = (m_running && !m_settling(cyc)) ? '1 : '0;
                s.busy    = m_settling(cyc) || m_draining(cyc);
                s.ready   = !s.busy;
                s.err     = m_err;
                s.clamped = m_clamped;
                sb_q.push_back(s);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(negedge clk);
            if (!reset && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("period_o", period_o, e.per);
                check("compare_o", compare_o, e.cmp);
                check("init_carr_o", init_carr_o, e.ini);
                check("pwm_onoff_o", W'(pwm_onoff_o), W'(e.on));
                check("busy", W'(busy), W'(e.busy));
                check("cmd_ready", W'(cmd_ready), W'(e.ready));
                check("err", W'(err), W'(e.err));
                check("clamped", W'(clamped), W'(e.clamped));
            end
        end
    end

    // Driver tasks assume they start just after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input int ch, input int p, input int c, input int ini);
        int waited = 0;
        cmd_op      = op;
        cmd_chan    = 3'(ch);
        cmd_period  = 16'(p);
        cmd_compare = 16'(c);
        cmd_init    = 16'(ini);
        cmd_valid   = 1'b1;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (last_acc != cyc && waited < 50);
        check("accept_within_budget", W'(last_acc == cyc), W'(1));
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_onoff_now", W'(pwm_onoff_o), '0);
        check("rst_ready_now", W'(cmd_ready), W'(1));
        check("rst_busy_now", W'(busy), '0);
        check("rst_err_now", W'(err), '0);
        check("rst_clamped_now", W'(clamped), '0);
        check("rst_period_now", period_o, '0);
        check("rst_compare_now", compare_o, '0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        send(OP_WRITE, 0, 1000, 400, 0);
        idle(2);
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(1, 16'hffff);
            send(OP_WRITE, $urandom_range(0, NCH - 1), p, $urandom_range(0, p), $urandom_range(0, 16'hffff));
            idle($urandom_range(0, 2));
        end
        send(OP_NOP, 0, 0, 0, 0);
        send(OP_STOP, 0, 0, 0, 0);
        idle(1);

        send(OP_START, 0, 0, 0, 0);
        idle(SETTLE + 2);
        send(OP_WRITE, 2, 500, 700, 3);
        idle(1);
        for (int k = 0; k < 6; k++) begin
            send(OP_WRITE, $urandom_range(0, NCH - 1), $urandom_range(0, 16'hffff),
                 $urandom_range(0, 16'hffff), $urandom_range(0, 16'hffff));
        end
        send(OP_NOP, 0, 0, 0, 0);

        // START issued right after STOP stays valid through the drain window.
        send(OP_STOP, 0, 0, 0, 0);
        send(OP_START, 0, 0, 0, 0);
        idle(SETTLE + 1);

        send(OP_WRITE, 5, 123, 45, 6);
        send(OP_START, 0, 0, 0, 0);
        idle(3);

        async_reset();
        idle(1);
        send(OP_WRITE, 1, 300, 100, 7);
        send(OP_START, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        async_reset();
        idle(1);

        send(OP_START, 0, 0, 0, 0);
        idle(SETTLE + 3);
        send(OP_STOP, 0, 0, 0, 0);
        idle(DRAIN + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
Command-driven sequencer that configures and starts/stops a bank of NCH pwm_16bits channels from one command port. It holds per-channel period / compare / init_carr configuration and drives pwm_onoff for all channels. Channels are enabled together after a settle window and disabled together, followed by a drain window that lets the dead-time and divider logic go idle. It sits between the processor-side register interface and the pwm_16bits instances.

Parameters:
NCH, 3, number of PWM channels driven (1..8)
SETTLE, 4, clk cycles between START acceptance and simultaneous channel enable (>=1)
DRAIN, 8, clk cycles held in STOPPING before a new START can be accepted (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready; transfer when cmd_valid && cmd_ready at rising clk
cmd_op  in  2  _seq_op: OP_NOP=0, OP_WRITE=1, OP_START=2, OP_STOP=3
cmd_chan  in  3  target channel for OP_WRITE
cmd_period  in  16  period value for OP_WRITE
cmd_compare  in  16  compare value for OP_WRITE
cmd_init  in  16  initial carrier value for OP_WRITE
period_o  out  NCH*16  per-channel period, channel i at [16i+15:16i]
compare_o  out  NCH*16  per-channel compare, same packing
init_carr_o  out  NCH*16  per-channel initial carrier, same packing
pwm_onoff_o  out  NCH  per-channel _pwm_onoff (1=ON); all bits always equal
busy  out  1  high in SETTLE or STOPPING
err  out  1  sticky illegal-command flag
clamped  out  1  sticky flag: a write had compare > period

Behaviour:
- Reset (async, active-high) sets state OFF, all config outputs 0, pwm_onoff_o 0, err 0, clamped 0, busy 0, cmd_ready 1, counter 0. Reset mid-SETTLE or mid-RUN disables all channels immediately, with no wait for a clock edge.
- States: OFF, SETTLE, RUN, STOPPING (_seq_state). cmd_ready = 1 in OFF and RUN, 0 in SETTLE and STOPPING.
- OP_NOP: accepted, no effect in any state.
- OP_WRITE (OFF or RUN): the addressed channel's period/compare/init_carr registers update at the accepting edge and are visible the next cycle. Other channels are unchanged.
- OP_WRITE with cmd_chan >= NCH: no register changes; err set.
- OP_WRITE with cmd_compare > cmd_period: compare is stored as cmd_period and clamped is set. Equality is legal.
- OP_START in OFF: go to SETTLE and load counter = SETTLE. The counter decrements each cycle in SETTLE. At the edge where the counter goes 1->0, go to RUN and set all pwm_onoff_o bits in that same edge. Acceptance at edge t gives pwm_onoff_o high after edge t+SETTLE.
- OP_START in RUN: ignored; err set.
- OP_STOP in RUN: all pwm_onoff_o bits clear at the accepting edge. Go to STOPPING with counter = DRAIN; decrement; at 1->0 go to OFF and assert cmd_ready.
- OP_STOP in OFF: ignored, no error.
- Config outputs hold their values through STOPPING and OFF; they are not cleared by STOP.
- err and clamped clear only on reset.
- Counter width: $clog2(max(SETTLE,DRAIN)+1).
- Write-vs-state collisions cannot occur, because cmd_ready=0 blocks all commands in SETTLE/STOPPING.

Decomposition:
- PKG_pwm gains _seq_op (2-bit enum) and _seq_state (2-bit enum). Existing `PWMCOUNT_WIDTH and _pwm_onoff are reused for widths and on/off encoding.
- One sub-module, pwm_chan_cfg: a single channel's period/compare/init register set with write-enable and compare clamp logic, instantiated NCH times via generate.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then WRITE ch0 period=1000 compare=400 init=0 -> compare_o[15:0]=400 one cycle later; other channels read 0; clamped=0.
- START with SETTLE=4, accepted at edge t -> busy=1 and cmd_ready=0 for 4 cycles; all pwm_onoff_o bits go 1 together after edge t+4; busy=0.
- In RUN, WRITE ch2 period=500 compare=700 -> compare_o ch2=500, clamped=1; pwm_onoff_o stays all ones.
- In RUN, STOP -> pwm_onoff_o=0 after accepting edge; cmd_ready=0 for 8 cycles (DRAIN=8); a START held valid throughout is accepted only once state is OFF.
- WRITE with cmd_chan=5 (NCH=3), and START while in RUN -> no config change; err=1 and stays 1 until reset.
- Assert reset asynchronously mid-SETTLE (counter=2) -> all outputs 0 and cmd_ready=1 immediately, without a clock edge; next START restarts the full 4-cycle settle.
